// File: rtl/mips_tb_pkg.sv
// Package: mips_tb_pkg
// Shared types and constants for the MIPS Harvard CPU bench run controller.
//   run_state_t    : controller state (IDLE, RST, RUN, DONE)
//   MIPS_BOOT_ADDR : reset vector fetched by the CPU on its first cycle
package mips_tb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_t;

  localparam logic [31:0] MIPS_BOOT_ADDR = 32'hBFC00000;

endpackage

// File: rtl/mips_tb_run_controller.sv
// Module: mips_tb_run_controller
// Run controller for MIPS Harvard CPU benches and FPGA self-test. Holds the CPU
// in reset for RESET_CYCLES enabled cycles, then lets it run (free-running or
// single-stepped), counts enabled cycles, and finishes on halt, timeout or a
// bad first fetch.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (port name: reset)
//   start             1-cycle pulse, accepted in IDLE or DONE
//   step_mode, step   single-step control; step is sampled each RUN cycle
//   check_en          compare register_v0 with expected_v0 at halt
//   expected_v0       expected $v0 value
//   active            CPU active flag
//   instr_address     CPU instruction address
//   register_v0       CPU $v0 debug output
//   cpu_reset         reset to CPU (combinational decode of state)
//   clk_enable        clock enable to CPU/data memory (combinational decode)
//   done/pass/timeout/boot_error  registered result flags
//   cycle_count       enabled RUN cycles before halt/timeout
//   result_v0         register_v0 captured at halt
module mips_tb_run_controller
  import mips_tb_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_CYCLES   = 1000,
  parameter int unsigned CNT_W        = 16,
  parameter logic [31:0] BOOT_ADDR    = MIPS_BOOT_ADDR,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic             check_en,
  input  logic [31:0]      expected_v0,
  input  logic             active,
  input  logic [31:0]      instr_address,
  input  logic [31:0]      register_v0,
  output logic             cpu_reset,
  output logic             clk_enable,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic             boot_error,
  output logic [CNT_W-1:0] cycle_count,
  output logic [31:0]      result_v0
);

  localparam int unsigned    RW       = $clog2(RESET_CYCLES + 1);
  localparam logic [RW-1:0]  RST_LOAD = RW'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  run_state_t       state_q, state_d;
  logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             first_q, first_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic             boot_error_q, boot_error_d;
  logic [31:0]      result_v0_q, result_v0_d;

  logic run_en;
  logic halt;

  assign run_en = step_mode ? step : 1'b1;
  assign halt   = !active && (instr_address == HALT_ADDR);

  // Decoded straight from state so an async reset takes effect immediately.
  assign cpu_reset  = (state_q == IDLE) || (state_q == RST);
  assign clk_enable = (state_q == RST) || ((state_q == RUN) && run_en);

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    cycle_count_d = cycle_count_q;
    first_d       = first_q;
    done_d        = done_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    boot_error_d  = boot_error_q;
    result_v0_d   = result_v0_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d       = RST;
          rst_cnt_d     = RST_LOAD;
          cycle_count_d = '0;
          first_d       = 1'b1;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          timeout_d     = 1'b0;
          boot_error_d  = 1'b0;
          result_v0_d   = '0;
        end
      end
      RST: begin
        // Counter is loaded with RESET_CYCLES-1 so RST lasts RESET_CYCLES cycles.
        if (rst_cnt_q == '0) state_d = RUN;
        else                 rst_cnt_d = rst_cnt_q - RW'(1);
      end
      RUN: begin
        if (run_en) begin
          first_d = 1'b0;
          // Priority: bad boot fetch, then halt, then count/timeout.
          if (first_q && (instr_address != BOOT_ADDR)) begin
            boot_error_d = 1'b1;
            done_d       = 1'b1;
            pass_d       = 1'b0;
            state_d      = DONE;
          end else if (halt) begin
            result_v0_d = register_v0;
            pass_d      = !check_en || (register_v0 == expected_v0);
            done_d      = 1'b1;
            state_d     = DONE;
          end else begin
            cycle_count_d = cycle_count_q + CNT_W'(1);
            if (cycle_count_q == CNT_LAST) begin
              timeout_d = 1'b1;
              done_d    = 1'b1;
              pass_d    = 1'b0;
              state_d   = DONE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rst_cnt_q     <= '0;
      cycle_count_q <= '0;
      first_q       <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      boot_error_q  <= 1'b0;
      result_v0_q   <= '0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      cycle_count_q <= cycle_count_d;
      first_q       <= first_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      boot_error_q  <= boot_error_d;
      result_v0_q   <= result_v0_d;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign boot_error  = boot_error_q;
  assign cycle_count = cycle_count_q;
  assign result_v0   = result_v0_q;

endmodule

// File: tb/tb_mips_tb_run_controller.sv
// Testbench for mips_tb_run_controller: a behavioural CPU stub fetches from the
// boot address after reset and advances one fetch per enabled cycle, halting
// after K fetches. Expected results per run are queued at start and checked
// by a monitor when done rises.
module tb_mips_tb_run_controller;

  localparam int          RC    = 2;
  localparam int          MC    = 10;
  localparam int          CW    = 16;
  localparam logic [31:0] BOOT  = 32'hBFC00000;
  localparam logic [31:0] HALTA = 32'h00000000;
  localparam int          NEVER = 1000000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          step_mode = 1'b0;
  logic          step = 1'b0;
  logic          check_en = 1'b0;
  logic [31:0]   expected_v0 = '0;
  logic          active;
  logic [31:0]   instr_address;
  logic [31:0]   register_v0;
  logic          cpu_reset, clk_enable, done, pass, timeout, boot_error;
  logic [CW-1:0] cycle_count;
  logic [31:0]   result_v0;

  mips_tb_run_controller #(
    .RESET_CYCLES(RC), .MAX_CYCLES(MC), .CNT_W(CW),
    .BOOT_ADDR(BOOT), .HALT_ADDR(HALTA)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
    .check_en(check_en), .expected_v0(expected_v0), .active(active),
    .instr_address(instr_address), .register_v0(register_v0),
    .cpu_reset(cpu_reset), .clk_enable(clk_enable), .done(done), .pass(pass),
    .timeout(timeout), .boot_error(boot_error), .cycle_count(cycle_count),
    .result_v0(result_v0)
  );

  always #5 clk = ~clk;

  // CPU stub configuration and state
  int          k_cfg = NEVER;
  bit          bad_cfg = 1'b0;
  logic [31:0] v0_cfg = '0;
  logic [31:0] stub_pc = BOOT;
  int          stub_fetches = 0;
  logic        stub_halted;

  assign stub_halted   = (stub_fetches >= k_cfg);
  assign active        = !stub_halted;
  assign instr_address = stub_halted ? HALTA : stub_pc;
  assign register_v0   = v0_cfg;

  always @(posedge clk) begin
    if (clk_enable) begin
      if (cpu_reset) begin
        stub_pc      <= bad_cfg ? 32'h00000004 : BOOT;
        stub_fetches <= 0;
      end else if (!stub_halted) begin
        stub_pc      <= stub_pc + 32'd4;
        stub_fetches <= stub_fetches + 1;
      end
    end
  end

  typedef struct {
    bit          pass;
    bit          timeout;
    bit          boot_error;
    int          cnt;
    logic [31:0] res;
    int          rst_cyc;
    int          en_cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Reference: outcome of one run from the run rules, given the stub's K.
  function automatic exp_t model(input int k, input bit bad, input logic [31:0] v0,
                                 input logic [31:0] ev, input bit ce);
    exp_t e;
    e.rst_cyc = RC;
    e.pass = 0; e.timeout = 0; e.boot_error = 0; e.res = '0;
    if (bad) begin
      e.boot_error = 1; e.cnt = 0; e.en_cyc = 1;
    end else if (k <= MC - 1) begin
      e.pass = !ce || (v0 == ev); e.cnt = k; e.res = v0; e.en_cyc = k + 1;
    end else begin
      e.timeout = 1; e.cnt = MC; e.en_cyc = MC;
    end
    return e;
  endfunction

  // Monitor
  int rst_seen = 0;
  int en_seen = 0;
  logic done_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (start && (done || (cpu_reset && !clk_enable))) begin
      rst_seen = 0;
      en_seen  = 0;
    end
    if (cpu_reset && clk_enable) rst_seen++;
    if (!cpu_reset && clk_enable) en_seen++;
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pass", 64'(pass), 64'(e.pass));
        chk("timeout", 64'(timeout), 64'(e.timeout));
        chk("boot_error", 64'(boot_error), 64'(e.boot_error));
        chk("cycle_count", 64'(cycle_count), 64'(e.cnt));
        chk("result_v0", 64'(result_v0), 64'(e.res));
        chk("reset_cycles", 64'(rst_seen), 64'(e.rst_cyc));
        chk("run_enabled_cycles", 64'(en_seen), 64'(e.en_cyc));
        chk("done_cpu_reset", 64'(cpu_reset), 64'd0);
        chk("done_clk_enable", 64'(clk_enable), 64'd0);
      end
    end
    done_prev = done;
  end

  // pat: 0 free-run, 1 random steps, 2 step every 6th cycle, 3 step held high
  task automatic do_run(input int k, input bit bad, input logic [31:0] v0,
                        input logic [31:0] ev, input bit ce, input int pat,
                        input bit inject);
    int n;
    k_cfg = k; bad_cfg = bad; v0_cfg = v0;
    expected_v0 = ev; check_en = ce;
    step_mode = (pat != 0); step = 1'b0;
    exp_q.push_back(model(k, bad, v0, ev, ce));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!done && n < 400) begin
      case (pat)
        1:       step = 1'($urandom_range(0, 1));
        2:       step = ((n % 6) == 5);
        3:       step = 1'b1;
        default: step = 1'b0;
      endcase
      start = inject && (n == 4);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    step  = 1'b0;
    if (!done) begin
      chk("run_completes", 64'd0, 64'd1);
      void'(exp_q.pop_back());
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    // reset state
    #12;
    chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("rst_clk_enable", 64'(clk_enable), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_boot_error", 64'(boot_error), 64'd0);
    chk("rst_cycle_count", 64'(cycle_count), 64'd0);
    chk("rst_result_v0", 64'(result_v0), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // directed scenarios
    do_run(4, 0, 32'h00018018, 32'h00018018, 1, 0, 0);
    do_run(4, 0, 32'h00018018, 32'h00006006, 1, 0, 0);
    do_run(4, 0, 32'h00018018, 32'h00006006, 0, 0, 0);
    do_run(NEVER, 0, 32'h12345678, 32'h12345678, 1, 0, 0);
    do_run(3, 0, 32'h0000abcd, 32'h0000abcd, 1, 2, 0);
    do_run(4, 1, 32'h00018018, 32'h00018018, 1, 0, 0);
    do_run(MC - 1, 0, 32'h00000055, 32'h00000055, 1, 0, 0);
    do_run(5, 0, 32'h00000077, 32'h00000077, 1, 3, 1);

    // reset in the middle of a run, then a clean rerun
    k_cfg = NEVER; bad_cfg = 0; step_mode = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (cycle_count != CW'(5) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midrun_reached_5", 64'(cycle_count), 64'd5);
    #2 reset = 1'b1;
    #1;
    chk("midrun_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("midrun_clk_enable", 64'(clk_enable), 64'd0);
    chk("midrun_cycle_count", 64'(cycle_count), 64'd0);
    chk("midrun_done", 64'(done), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    do_run(4, 0, 32'h00018018, 32'h00018018, 1, 0, 0);

    // randomized runs
    for (int r = 0; r < 16; r++) begin
      int          k;
      bit          bad, ce, inj;
      logic [31:0] v0, ev;
      int          pat;
      k   = $urandom_range(1, 12);
      bad = ($urandom_range(0, 7) == 0);
      v0  = $urandom;
      ev  = ($urandom_range(0, 1) == 1) ? v0 : $urandom;
      ce  = 1'($urandom_range(0, 1));
      pat = $urandom_range(0, 3);
      inj = ($urandom_range(0, 3) == 0);
      do_run(k, bad, v0, ev, ce, pat, inj);
    end

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
